// File: rtl/bp_nonsynth_if_monitor.sv
// bp_nonsynth_if_monitor
//
// Runtime protocol monitor for num_chan_p independent ready/valid (ready_and)
// channels. Each channel runs a two-state FSM (IDLE, PEND) that checks:
//   - valid stays high until the handshake (code 1, valid drop)
//   - payload stays constant while pending (code 2, data change)
//   - valid is not left waiting for timeout_p cycles (code 3, stall)
// Completed handshakes are counted per channel with saturating counters.
// The first violation is latched (sticky flag, channel, code) until reset.
//
// Ports:
//   clk_i         clock
//   reset_i       synchronous active-high reset
//   en_i          monitor enable; low suspends checking and counting
//   v_i           per-channel valid
//   ready_and_i   per-channel ready (consumer side)
//   data_i        per-channel payload, channel c at [c*data_width_p +: data_width_p]
//   error_o       sticky violation flag
//   error_chan_o  channel of first violation
//   error_code_o  first violation code: 0 none, 1 valid drop, 2 data change, 3 stall
//   txn_count_o   per-channel saturating handshake counts, channel c at
//                 [c*count_width_p +: count_width_p]
//
// Optional build macro BP_NONSYNTH_IF_MONITOR_FATAL_EN: when defined, the
// first violation is printed and simulation ends with $fatal. When undefined
// the monitor is silent and only the error outputs reflect the violation.

module bp_nonsynth_if_monitor #(
   parameter int num_chan_p    = 4,
   parameter int data_width_p  = 64,
   parameter int timeout_p     = 1024,
   parameter int count_width_p = 32,
   localparam int chan_w_lp    = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   en_i,
   input  logic [num_chan_p-1:0]                  v_i,
   input  logic [num_chan_p-1:0]                  ready_and_i,
   input  logic [num_chan_p*data_width_p-1:0]     data_i,
   output logic                                   error_o,
   output logic [chan_w_lp-1:0]                   error_chan_o,
   output logic [1:0]                             error_code_o,
   output logic [num_chan_p*count_width_p-1:0]    txn_count_o
);

   localparam int stall_w_lp = $clog2(timeout_p + 1);

   localparam logic [0:0] idle_s = 1'b0;
   localparam logic [0:0] pend_s = 1'b1;

   localparam logic [stall_w_lp-1:0] stall_one_lp     = stall_w_lp'(1);
   localparam logic [stall_w_lp-1:0] stall_timeout_lp = stall_w_lp'(timeout_p);

   function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] val);
      return (&val) ? val : val + 1'b1;
   endfunction

   logic [0:0]              state_p0 [num_chan_p];
   logic [0:0]              state_p1 [num_chan_p];
   logic [stall_w_lp-1:0]   stall_p0 [num_chan_p];
   logic [stall_w_lp-1:0]   stall_p1 [num_chan_p];
   logic [data_width_p-1:0] data_p0  [num_chan_p];
   logic [data_width_p-1:0] hold_p1  [num_chan_p];
   logic [count_width_p-1:0] cnt_p1  [num_chan_p];
   logic [1:0]              code_p0  [num_chan_p];
   logic [num_chan_p-1:0]   hs_p0;
   logic [num_chan_p-1:0]   capture_p0;

   logic                    viol_p0;
   logic [chan_w_lp-1:0]    viol_chan_p0;
   logic [1:0]              viol_code_p0;

   logic                    error_p1;
   logic [chan_w_lp-1:0]    error_chan_p1;
   logic [1:0]              error_code_p1;

   // Stage 0: per-channel FSM next state and violation detection from this cycle's inputs
   always_comb begin
      for (int c = 0; c < num_chan_p; c++) begin
         data_p0[c]    = data_i[c*data_width_p +: data_width_p];
         hs_p0[c]      = en_i & v_i[c] & ready_and_i[c];
         state_p0[c]   = state_p1[c];
         stall_p0[c]   = stall_p1[c];
         code_p0[c]    = 2'd0;
         capture_p0[c] = 1'b0;
         if (!en_i) begin
            state_p0[c] = idle_s;
            stall_p0[c] = '0;
         end else if (state_p1[c] == idle_s) begin
            if (v_i[c] && !ready_and_i[c]) begin
               state_p0[c]   = pend_s;
               stall_p0[c]   = stall_one_lp;
               capture_p0[c] = 1'b1;
            end
         end else begin
            if (!v_i[c]) begin
               state_p0[c] = idle_s;
               stall_p0[c] = '0;
               code_p0[c]  = 2'd1;
            end else if (data_p0[c] != hold_p1[c]) begin
               code_p0[c] = 2'd2;
               if (ready_and_i[c]) begin
                  state_p0[c] = idle_s;
                  stall_p0[c] = '0;
               end else begin
                  // Track the new payload so one change is reported once,
                  // not on every following cycle.
                  capture_p0[c] = 1'b1;
               end
            end else if (ready_and_i[c]) begin
               state_p0[c] = idle_s;
               stall_p0[c] = '0;
            end else if (stall_p1[c] != stall_timeout_lp) begin
               // Counter stops at timeout so the stall is flagged only once.
               stall_p0[c] = stall_p1[c] + 1'b1;
               if (stall_p0[c] == stall_timeout_lp) begin
                  code_p0[c] = 2'd3;
               end
            end
         end
      end
   end

   // Lowest channel index wins among simultaneous violations.
   always_comb begin
      viol_p0      = 1'b0;
      viol_chan_p0 = '0;
      viol_code_p0 = 2'd0;
      for (int c = num_chan_p - 1; c >= 0; c--) begin
         if (code_p0[c] != 2'd0) begin
            viol_p0      = 1'b1;
            viol_chan_p0 = chan_w_lp'(c);
            viol_code_p0 = code_p0[c];
         end
      end
   end

   // Stage 1: registered FSM state, counters and first-error record
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int c = 0; c < num_chan_p; c++) begin
            state_p1[c] <= idle_s;
            stall_p1[c] <= '0;
            cnt_p1[c]   <= '0;
         end
         error_p1      <= 1'b0;
         error_chan_p1 <= '0;
         error_code_p1 <= 2'd0;
      end else begin
         for (int c = 0; c < num_chan_p; c++) begin
            state_p1[c] <= state_p0[c];
            stall_p1[c] <= stall_p0[c];
            if (hs_p0[c]) begin
               cnt_p1[c] <= sat_inc(cnt_p1[c]);
            end
         end
         if (!error_p1 && viol_p0) begin
            error_p1      <= 1'b1;
            error_chan_p1 <= viol_chan_p0;
            error_code_p1 <= viol_code_p0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int c = 0; c < num_chan_p; c++) begin
         if (capture_p0[c]) begin
            hold_p1[c] <= data_p0[c];
         end
      end
   end

   assign error_o      = error_p1;
   assign error_chan_o = error_chan_p1;
   assign error_code_o = error_code_p1;

   always_comb begin
      for (int c = 0; c < num_chan_p; c++) begin
         txn_count_o[c*count_width_p +: count_width_p] = cnt_p1[c];
      end
   end

`ifdef BP_NONSYNTH_IF_MONITOR_FATAL_EN
   always @(posedge clk_i) begin
      if (!reset_i && !error_p1 && viol_p0) begin
         $display("bp_nonsynth_if_monitor: protocol violation chan=%0d code=%0d held=%h data=%h",
                  viol_chan_p0, viol_code_p0, hold_p1[viol_chan_p0], data_p0[viol_chan_p0]);
         $fatal(1, "bp_nonsynth_if_monitor: terminating on protocol violation");
      end
   end
`else
   // Silent build: violations are visible only on the error outputs.
`endif

endmodule

// File: tb/tb_bp_nonsynth_if_monitor.sv
module tb_bp_nonsynth_if_monitor;

   localparam int NC = 4;
   localparam int DW = 64;
   localparam int TO = 8;
   localparam int CW = 4;

   logic             clk;
   logic             reset;
   logic             en;
   logic [NC-1:0]    v;
   logic [NC-1:0]    rdy;
   logic [NC*DW-1:0] data;
   logic             error;
   logic [1:0]       error_chan;
   logic [1:0]       error_code;
   logic [NC*CW-1:0] txn_count;

   bp_nonsynth_if_monitor #(
      .num_chan_p   (NC),
      .data_width_p (DW),
      .timeout_p    (TO),
      .count_width_p(CW)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .en_i        (en),
      .v_i         (v),
      .ready_and_i (rdy),
      .data_i      (data),
      .error_o     (error),
      .error_chan_o(error_chan),
      .error_code_o(error_code),
      .txn_count_o (txn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [3:0]  v;
      logic [3:0]  rdy;
      logic [63:0] d1;
      logic        exp_err;
      logic [1:0]  exp_chan;
      logic [1:0]  exp_code;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic r, input logic e, input logic [3:0] vv, input logic [3:0] rr,
                      input logic [63:0] d1, input logic ee, input logic [1:0] ech,
                      input logic [1:0] ecd, input logic [15:0] cnt);
      vec_t t;
      t.rst = r; t.en = e; t.v = vv; t.rdy = rr; t.d1 = d1;
      t.exp_err = ee; t.exp_chan = ech; t.exp_code = ecd; t.exp_cnt = cnt;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then check registered outputs.
   task automatic apply(input vec_t t, input string tag);
      reset = t.rst;
      en    = t.en;
      v     = t.v;
      rdy   = t.rdy;
      data  = {64'h0, 64'h0, t.d1, 64'h0};
      @(posedge clk);
      #1;
      check({tag, ".err"},  {15'h0, error},      {15'h0, t.exp_err});
      check({tag, ".chan"}, {14'h0, error_chan}, {14'h0, t.exp_chan});
      check({tag, ".code"}, {14'h0, error_code}, {14'h0, t.exp_code});
      check({tag, ".cnt"},  txn_count,           t.exp_cnt);
   endtask

   initial begin
      vec_t t;
      reset = 1'b1; en = 1'b0; v = '0; rdy = '0; data = '0;

      // Reset
      add(1, 1, 4'b0000, 4'b0000, 64'h0, 0, 0, 0, 16'h0000);
      add(1, 1, 4'b0000, 4'b0000, 64'h0, 0, 0, 0, 16'h0000);
      // Clean traffic on ch0: 5 direct handshakes, then 3 after 2 stall cycles each
      for (int i = 1; i <= 5; i++) add(0, 1, 4'b0001, 4'b0001, 64'h0, 0, 0, 0, 16'(i));
      for (int k = 0; k < 3; k++) begin
         add(0, 1, 4'b0001, 4'b0000, 64'h0, 0, 0, 0, 16'(5 + k));
         add(0, 1, 4'b0001, 4'b0000, 64'h0, 0, 0, 0, 16'(5 + k));
         add(0, 1, 4'b0001, 4'b0001, 64'h0, 0, 0, 0, 16'(6 + k));
      end
      add(0, 1, 4'b0000, 4'b0000, 64'h0, 0, 0, 0, 16'h0008);
      // Valid drop on ch2
      for (int i = 0; i < 3; i++) add(0, 1, 4'b0100, 4'b0000, 64'h0, 0, 0, 0, 16'h0008);
      add(0, 1, 4'b0000, 4'b0000, 64'h0, 1, 2, 1, 16'h0008);
      add(1, 1, 4'b0000, 4'b0000, 64'h0, 0, 0, 0, 16'h0000);
      // Data change on ch1 together with valid drop on ch3; later ch0 violation is ignored
      add(0, 1, 4'b1010, 4'b0000, 64'hA5, 0, 0, 0, 16'h0000);
      add(0, 1, 4'b0010, 4'b0000, 64'hA6, 1, 1, 2, 16'h0000);
      add(0, 1, 4'b0011, 4'b0000, 64'hA6, 1, 1, 2, 16'h0000);
      add(0, 1, 4'b0010, 4'b0000, 64'hA6, 1, 1, 2, 16'h0000);
      add(0, 1, 4'b0010, 4'b0010, 64'hA6, 1, 1, 2, 16'h0010);
      add(1, 1, 4'b0000, 4'b0000, 64'h0, 0, 0, 0, 16'h0000);
      // Enable handling on ch1
      add(0, 1, 4'b0010, 4'b0010, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 1, 4'b0010, 4'b0000, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 0, 4'b0010, 4'b0000, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 0, 4'b0000, 4'b0000, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 0, 4'b0010, 4'b0010, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 1, 4'b0000, 4'b0000, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 0, 4'b0010, 4'b0000, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 1, 4'b0010, 4'b0000, 64'h5, 0, 0, 0, 16'h0010);
      add(0, 1, 4'b0000, 4'b0000, 64'h5, 1, 1, 1, 16'h0010);
      // Reset while ch2 is pending
      add(0, 1, 4'b0100, 4'b0000, 64'h0, 1, 1, 1, 16'h0010);
      add(1, 1, 4'b0100, 4'b0000, 64'h0, 0, 0, 0, 16'h0000);
      add(0, 1, 4'b0000, 4'b0000, 64'h0, 0, 0, 0, 16'h0000);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Stall watchdog on ch0: flagged on the 8th waiting cycle, then handshake on cycle 20
      for (int i = 1; i <= 20; i++) begin
         t.rst = 0; t.en = 1; t.v = 4'b0001; t.d1 = 64'h0;
         t.rdy      = (i == 20) ? 4'b0001 : 4'b0000;
         t.exp_err  = (i >= 8);
         t.exp_chan = 2'd0;
         t.exp_code = (i >= 8) ? 2'd3 : 2'd0;
         t.exp_cnt  = (i == 20) ? 16'h0001 : 16'h0000;
         apply(t, $sformatf("stall%0d", i));
      end
      t.v = 4'b0000; t.rdy = 4'b0000; t.exp_err = 1; t.exp_code = 2'd3; t.exp_cnt = 16'h0001;
      apply(t, "stall_idle");

      // Counter saturation on ch0
      t.rst = 1; t.v = 4'b0000; t.exp_err = 0; t.exp_code = 0; t.exp_cnt = 16'h0000;
      apply(t, "sat_reset");
      for (int i = 1; i <= 20; i++) begin
         t.rst = 0; t.en = 1; t.v = 4'b0001; t.rdy = 4'b0001;
         t.exp_err = 0; t.exp_chan = 0; t.exp_code = 0;
         t.exp_cnt = (i > 15) ? 16'h000F : 16'(i);
         apply(t, $sformatf("sat%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
